fifo_sync_ext: RTL

Parametrised next-generation single-clock FIFO for the shared submodule library. It adds four things over the basic synchronous FIFO: a selectable first-word-fall-through (FWFT) read mode, an exact fill-count output, runtime-programmable almost-full/almost-empty thresholds, and a synchronous flush. It sits between AXI-stream/DMA producers and consumers inside a single clock domain, and uses block RAM with a registered read port.

---
 rtl/fifo_sync_ext.sv | 103 ++++++++++
 1 files changed

// File: rtl/fifo_sync_ext.sv
// fifo_sync_ext: single-clock FIFO with standard/FWFT read modes, fill count, programmable thresholds and flush.
// Define FIFO_SYNC_EXT_ERR_FLAGS_EN to add sticky overflow/underflow flags cleared by err_clr.
module fifo_sync_ext #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  almost_empty,
    input  logic [ADDR_WIDTH:0]   aempty_thresh,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam bit FW    = FWFT != 0;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, mem_count;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d, ov_q, ov_d;
    logic                  wr_acc, rd_pop;

    // rd_pop moves a word out of memory: a standard read, or an FWFT prefetch into the output register
    always_comb begin
        mem_count    = wr_ptr_q - rd_ptr_q;
        full         = mem_count == PW'(DEPTH);
        empty        = FW ? ~ov_q : (mem_count == '0);
        wr_acc       = wr_en & ~full & ~flush;
        rd_pop       = ~flush & (mem_count != '0) & (FW ? (~ov_q | rd_en) : rd_en);
        wr_ptr_d     = flush ? '0 : wr_ptr_q + PW'(wr_acc);
        rd_ptr_d     = flush ? '0 : rd_ptr_q + PW'(rd_pop);
        rd_data_d    = rd_pop ? mem[rd_ptr_q[ADDR_WIDTH-1:0]] : rd_data_q;
        ov_d         = FW & ~flush & (rd_pop | (ov_q & ~rd_en));
        rd_valid_d   = ~flush & rd_pop;
        count        = mem_count + PW'(FW & ov_q);
        rd_valid     = FW ? ov_q : rd_valid_q;
        rd_data      = rd_data_q;
        almost_full  = count >= afull_thresh;
        almost_empty = count <= aempty_thresh;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ov_q       <= ov_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
    end

`ifdef FIFO_SYNC_EXT_ERR_FLAGS_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    // a new error outranks a coincident clear
    always_comb begin
        overflow_d  = (wr_en & full) | (overflow_q & ~err_clr);
        underflow_d = (rd_en & empty) | (underflow_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif
endmodule
